uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, 2-flop input synchronizer, re-arm after a framing error.
// Optional UART_RX_MAJORITY_EN selects a 2-of-3 vote around each sample point.
module uart_rx #(
    parameter int unsigned CLK_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned CNT_W = 14;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_PER_BIT / 2);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic               armed, armed_next;
    logic [7:0]         shreg, shreg_next;
    logic [7:0]         rx_data_next;
    logic               rx_valid_next;
    logic               rx_frame_err_next;
    logic               rx_busy_next;
    logic               rx_meta, rx_s;
    logic               bit_c;

    // Two-flop synchronizer; idle-high reset value avoids a false start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // History of the two cycles preceding the sample point for the 2-of-3 vote.
    logic [1:0] rx_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_s};
        end
    end

    assign bit_c = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
    assign bit_c = rx_s;
`endif

    always_comb begin
        state_next        = state;
        cnt_next          = cnt + CNT_W'(1);
        idx_next          = idx;
        armed_next        = armed;
        shreg_next        = shreg;
        rx_data_next      = rx_data;
        rx_valid_next     = 1'b0;
        rx_frame_err_next = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (rx_s) begin
                    armed_next = 1'b1;
                end else if (armed) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_BIT) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = bit_c ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_next        = '0;
                    shreg_next[idx] = bit_c;
                    idx_next        = idx + IDX_W'(1);
                    if (idx == IDX_W'(7)) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (bit_c) begin
                        rx_data_next  = shreg;
                        rx_valid_next = 1'b1;
                    end else begin
                        // A low stop bit may be a break; wait for idle before re-arming.
                        rx_frame_err_next = 1'b1;
                        armed_next        = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        rx_busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            armed        <= 1'b1;
            shreg        <= '0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            idx          <= idx_next;
            armed        <= armed_next;
            shreg        <= shreg_next;
            rx_data      <= rx_data_next;
            rx_valid     <= rx_valid_next;
            rx_frame_err <= rx_frame_err_next;
            rx_busy      <= rx_busy_next;
        end
    end

endmodule
